// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller for the RV32 datapath: fetch handshake,
// DECODE/EXEC/WB stepping, datapath enables/selects, cycle/instret counters, halt.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rd,
  input  logic             br_taken,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic             wb_sel,
  output logic             rf_we,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {C_OP, C_OPIMM, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH} cls_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t           state_q;
  cls_t             cls_q;
  logic [1:0]       err_q;
  logic [7:0]       tmo_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] ret_q;

  cls_t dec_cls;
  logic dec_valid;

  // SYSTEM is deliberately not a valid class: it only ever leads to HALT.
  always_comb begin
    dec_cls   = C_OP;
    dec_valid = 1'b1;
    case (opcode)
      OPC_OP:     dec_cls = C_OP;
      OPC_OPIMM:  dec_cls = C_OPIMM;
      OPC_LUI:    dec_cls = C_LUI;
      OPC_AUIPC:  dec_cls = C_AUIPC;
      OPC_JAL:    dec_cls = C_JAL;
      OPC_JALR:   dec_cls = C_JALR;
      OPC_BRANCH: dec_cls = C_BRANCH;
      default:    dec_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_OP;
      err_q   <= 2'd0;
      tmo_q   <= 8'd0;
      cyc_q   <= '0;
      ret_q   <= '0;
    end else begin
      if (state_q != S_HALT) cyc_q <= cyc_q + 1'b1;
      case (state_q)
        S_FETCH: begin
          if (imem_req_ready) begin
            tmo_q   <= 8'd0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state_q <= S_DECODE;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= S_HALT;
            err_q   <= 2'd3;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_DECODE: begin
          if (dec_valid) begin
            cls_q   <= dec_cls;
            state_q <= S_EXEC;
          end else if (opcode == OPC_SYSTEM && funct3 == 3'b000) begin
            state_q <= S_HALT;
            err_q   <= 2'd1;
          end else begin
            state_q <= S_HALT;
            err_q   <= 2'd2;
          end
        end
        S_EXEC: state_q <= S_WB;
        S_WB: begin
          ret_q   <= ret_q + 1'b1;
          state_q <= S_FETCH;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  // Outputs are forced low while rst is high so nothing leaks from a stale state.
  always_comb begin
    imem_req_valid = 1'b0;
    ir_we          = 1'b0;
    pc_we          = 1'b0;
    pc_sel         = 2'd0;
    alu_a_sel      = 2'd0;
    alu_b_sel      = 1'b0;
    wb_sel         = 1'b0;
    rf_we          = 1'b0;
    halted         = 1'b0;
    err_code       = 2'd0;
    cycle_cnt      = '0;
    instret_cnt    = '0;
    if (!rst) begin
      err_code    = err_q;
      cycle_cnt   = cyc_q;
      instret_cnt = ret_q;
      case (state_q)
        S_FETCH: imem_req_valid = 1'b1;
        S_WAIT:  ir_we = imem_rsp_valid;
        S_EXEC, S_WB: begin
          case (cls_q)
            C_OPIMM: alu_b_sel = 1'b1;
            C_LUI:   begin alu_a_sel = 2'd2; alu_b_sel = 1'b1; end
            C_AUIPC: begin alu_a_sel = 2'd1; alu_b_sel = 1'b1; end
            C_JAL:   begin alu_a_sel = 2'd1; alu_b_sel = 1'b1; end
            C_JALR:  alu_b_sel = 1'b1;
            default: ;
          endcase
          if (state_q == S_WB) begin
            pc_we = 1'b1;
            case (cls_q)
              C_JAL:    pc_sel = 2'd1;
              C_JALR:   pc_sel = 2'd2;
              C_BRANCH: pc_sel = br_taken ? 2'd1 : 2'd0;
              default:  pc_sel = 2'd0;
            endcase
            wb_sel = (cls_q == C_JAL) || (cls_q == C_JALR);
            rf_we  = (cls_q != C_BRANCH) && (rd != 5'd0);
          end
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
